// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target peripheral:
// register offsets, register bit positions, reset value, FSM states.
package spi_pkg;

    localparam logic [11:0] CFG_ADDR  = 12'h000;
    localparam logic [11:0] STAT_ADDR = 12'h004;
    localparam logic [11:0] DATA_ADDR = 12'h008;

    localparam int CFG_CPHA = 0;
    localparam int CFG_CPOL = 1;
    localparam int CFG_MSB  = 2;
    localparam int CFG_ACS  = 3;
    localparam int CFG_EN   = 4;
    localparam int CFG_RXIE = 5;
    localparam int CFG_TXIE = 6;
    localparam int CFG_OVIE = 7;

    localparam int ST_RXV  = 0;
    localparam int ST_TXE  = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_SEL  = 3;
    localparam int ST_BUSY = 4;

    localparam logic [7:0] CFG_DEFAULT = 8'h04;

`ifdef SPI_TARGET_IRQ_EN
    localparam logic [7:0] CFG_MASK = 8'hFF;
`else
    localparam logic [7:0] CFG_MASK = 8'h1F;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spiState_t;

    function automatic logic outBit(input logic [7:0] v, input logic msb);
        return msb ? v[7] : v[0];
    endfunction

    function automatic logic [7:0] shiftIn(input logic [7:0] v, input logic b,
                                           input logic msb);
        return msb ? {v[6:0], b} : {b, v[7:1]};
    endfunction

endpackage

// File: rtl/spi_target_sync.sv
// Synchronises sclk/cs/mosi into clk and derives leading/trailing sclk edges.
// Ports: clk, rst (async, active-low), raw pins in; csActive, mosi, edge pulses out.
module spi_target_sync
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclkPin,
    input  logic csPin,
    input  logic mosiPin,
    input  logic cpol,
    input  logic activeHighCs,
    output logic csActive,
    output logic mosi,
    output logic leadEdge,
    output logic trailEdge
);

    logic [SYNC_STAGES-1:0] sclkPipe;
    logic [SYNC_STAGES-1:0] csPipe;
    logic [SYNC_STAGES-1:0] mosiPipe;
    logic                   sclkPrev;
    logic                   sclkNow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclkPipe <= '0;
            csPipe   <= '1;
            mosiPipe <= '0;
            sclkPrev <= 1'b0;
        end else begin
            sclkPipe <= {sclkPipe[SYNC_STAGES-2:0], sclkPin};
            csPipe   <= {csPipe[SYNC_STAGES-2:0], csPin};
            mosiPipe <= {mosiPipe[SYNC_STAGES-2:0], mosiPin};
            sclkPrev <= sclkPipe[SYNC_STAGES-1];
        end
    end

    assign sclkNow  = sclkPipe[SYNC_STAGES-1];
    assign mosi     = mosiPipe[SYNC_STAGES-1];
    assign csActive = activeHighCs ? csPipe[SYNC_STAGES-1]
                                   : !csPipe[SYNC_STAGES-1];

    // Leading edge leaves the idle (CPOL) level, trailing edge returns to it.
    assign leadEdge  = (sclkPrev == cpol) && (sclkNow != cpol);
    assign trailEdge = (sclkPrev != cpol) && (sclkNow == cpol);

endmodule

// File: rtl/spi_target_device.sv
// SPI target peripheral: config/status/data registers on the peripheral bus.
// Ports: bus (enable/we/oe/address/byteSelect/dataRead/dataWrite/busy/requestOutput),
// SPI pins (sclk, cs, mosi in; miso, miso_en out). Macro SPI_TARGET_IRQ_EN adds irq.
module spi_target_device
    import spi_pkg::*;
#(
    parameter logic [3:0] ID          = 4'h0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        peripheralEnable,
    input  logic        peripheralBus_we,
    input  logic        peripheralBus_oe,
    output logic        peripheralBus_busy,
    input  logic [15:0] peripheralBus_address,
    input  logic [3:0]  peripheralBus_byteSelect,
    output logic [31:0] peripheralBus_dataRead,
    input  logic [31:0] peripheralBus_dataWrite,
    output logic        requestOutput,
    input  logic        spi_sclk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_en
`ifdef SPI_TARGET_IRQ_EN
    ,
    output logic        irq
`endif
);

    spiState_t   state, nextState;
    logic [7:0]  cfg, rxHold, txHold, rxShift, txShift, rxNext, txNext;
    logic        rxValid, txEmpty, overrun, misoBit;
    logic [2:0]  bitCount;
    logic        csActive, mosiSync, leadEdge, trailEdge;
    logic        cpha, cpol, msbFirst, enable;
    logic        goActive, goIdle, running, sample, present, byteDone, txLoad;
    logic [11:0] localAddr;
    logic        devSel, regHit, wrCfg, wrStat, wrData, rdData;
    logic [31:0] statusWord;
    logic        unusedBits;

    assign cpha     = cfg[CFG_CPHA];
    assign cpol     = cfg[CFG_CPOL];
    assign msbFirst = cfg[CFG_MSB];
    assign enable   = cfg[CFG_EN];

    spi_target_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
        .clk          (clk),
        .rst          (rst),
        .sclkPin      (spi_sclk),
        .csPin        (spi_cs),
        .mosiPin      (spi_mosi),
        .cpol         (cpol),
        .activeHighCs (cfg[CFG_ACS]),
        .csActive     (csActive),
        .mosi         (mosiSync),
        .leadEdge     (leadEdge),
        .trailEdge    (trailEdge)
    );

    // Bus decode
    assign localAddr  = peripheralBus_address[11:0];
    assign devSel     = peripheralEnable && (peripheralBus_address[15:12] == ID);
    assign regHit     = localAddr inside {CFG_ADDR, STAT_ADDR, DATA_ADDR};
    assign requestOutput = devSel && peripheralBus_oe && regHit;
    assign wrCfg  = devSel && peripheralBus_we && (localAddr == CFG_ADDR)
                    && peripheralBus_byteSelect[0];
    assign wrStat = devSel && peripheralBus_we && (localAddr == STAT_ADDR)
                    && peripheralBus_byteSelect[0];
    assign wrData = devSel && peripheralBus_we && (localAddr == DATA_ADDR)
                    && peripheralBus_byteSelect[0];
    assign rdData = devSel && peripheralBus_oe && (localAddr == DATA_ADDR);
    assign peripheralBus_busy = 1'b0;
    assign unusedBits = ^{peripheralBus_byteSelect[3:1],
                          peripheralBus_dataWrite[31:8]};

    assign statusWord = {27'd0, (bitCount != 3'd0), csActive,
                         overrun, txEmpty, rxValid};

    always_comb begin
        peripheralBus_dataRead = '1;
        if (requestOutput) begin
            unique case (1'b1)
                localAddr == CFG_ADDR:  peripheralBus_dataRead = {24'd0, cfg};
                localAddr == STAT_ADDR: peripheralBus_dataRead = statusWord;
                localAddr == DATA_ADDR: peripheralBus_dataRead = {24'd0, rxHold};
            endcase
        end
    end

    // FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (csActive && enable) nextState = ACTIVE;
            ACTIVE:  if (!csActive || !enable) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign goActive = (state == IDLE) && (nextState == ACTIVE);
    assign goIdle   = (state == ACTIVE) && (nextState == IDLE);
    assign running  = (state == ACTIVE) && (nextState == ACTIVE);
    assign sample   = running && (cpha ? trailEdge : leadEdge);
    // CPHA=0: the trailing edge right after a byte completes must not
    // shift, or the first bit of the freshly loaded byte would be lost.
    assign present  = running && (cpha ? leadEdge
                                       : (trailEdge && bitCount != 3'd0));
    assign byteDone = sample && (bitCount == 3'd7);
    assign txLoad   = goActive || byteDone;
    assign rxNext   = shiftIn(rxShift, mosiSync, msbFirst);
    assign txNext   = txEmpty ? 8'hFF : txHold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg      <= CFG_DEFAULT;
            bitCount <= 3'd0;
            rxShift  <= 8'd0;
            txShift  <= 8'd0;
            misoBit  <= 1'b0;
            txHold   <= 8'd0;
            txEmpty  <= 1'b1;
            rxHold   <= 8'd0;
            rxValid  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (wrCfg) cfg <= peripheralBus_dataWrite[7:0] & CFG_MASK;

            if (goActive || goIdle) bitCount <= 3'd0;
            else if (sample)        bitCount <= bitCount + 3'd1;

            if (sample) rxShift <= rxNext;

            if (goActive)     misoBit <= 1'b0;
            else if (present) misoBit <= outBit(txShift, msbFirst);

            if (txLoad)       txShift <= txNext;
            else if (present) txShift <= shiftIn(txShift, 1'b1, msbFirst);

            // A same-cycle write wins over the load consuming txHold.
            if (wrData) begin
                txHold  <= peripheralBus_dataWrite[7:0];
                txEmpty <= 1'b0;
            end else if (txLoad && !txEmpty) begin
                txEmpty <= 1'b1;
            end

            if (byteDone && !rxValid) begin
                rxHold  <= rxNext;
                rxValid <= 1'b1;
            end else if (rdData) begin
                rxValid <= 1'b0;
            end

            if (byteDone && rxValid) overrun <= 1'b1;
            else if (wrStat && peripheralBus_dataWrite[ST_OVR]) overrun <= 1'b0;
        end
    end

    assign spi_miso_en = (state == ACTIVE);
    assign spi_miso    = spi_miso_en
                         && (cpha ? misoBit : outBit(txShift, msbFirst));

`ifdef SPI_TARGET_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else      irq <= (rxValid & cfg[CFG_RXIE])
                       | (txEmpty & cfg[CFG_TXIE])
                       | (overrun & cfg[CFG_OVIE]);
    end
`endif

endmodule

// File: tb/tb_spi_target_device.sv
// Scoreboard bench for spi_target_device: bus reads and miso bytes are
// checked by a monitor against expectations queued by the stimulus.
`timescale 1ns/1ps
module tb_spi_target_device;

    localparam int HALF = 80;
    localparam logic [15:0] A_CFG  = 16'h0000;
    localparam logic [15:0] A_STAT = 16'h0004;
    localparam logic [15:0] A_DATA = 16'h0008;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        peripheralEnable = 1'b0;
    logic        peripheralBus_we = 1'b0;
    logic        peripheralBus_oe = 1'b0;
    logic        peripheralBus_busy;
    logic [15:0] peripheralBus_address = 16'h0;
    logic [3:0]  peripheralBus_byteSelect = 4'h0;
    logic [31:0] peripheralBus_dataRead;
    logic [31:0] peripheralBus_dataWrite = 32'h0;
    logic        requestOutput;
    logic        spi_sclk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_en;
`ifdef SPI_TARGET_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    spi_target_device dut (
        .clk                      (clk),
        .rst                      (rst),
        .peripheralEnable         (peripheralEnable),
        .peripheralBus_we         (peripheralBus_we),
        .peripheralBus_oe         (peripheralBus_oe),
        .peripheralBus_busy       (peripheralBus_busy),
        .peripheralBus_address    (peripheralBus_address),
        .peripheralBus_byteSelect (peripheralBus_byteSelect),
        .peripheralBus_dataRead   (peripheralBus_dataRead),
        .peripheralBus_dataWrite  (peripheralBus_dataWrite),
        .requestOutput            (requestOutput),
        .spi_sclk                 (spi_sclk),
        .spi_cs                   (spi_cs),
        .spi_mosi                 (spi_mosi),
        .spi_miso                 (spi_miso),
        .spi_miso_en              (spi_miso_en)
`ifdef SPI_TARGET_IRQ_EN
        ,
        .irq                      (irq)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        req;
    } busExp_t;

    busExp_t    busQ[$];
    logic [7:0] expMisoQ[$];
    logic [7:0] gotMisoQ[$];
    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a read or a miso byte.
    initial begin
        busExp_t    e;
        logic [7:0] g;
        logic [7:0] x;
        forever begin
            @(negedge clk);
            if (peripheralEnable && peripheralBus_oe) begin
                if (busQ.size() == 0) begin
                    check("unexpected_read", 32'd1, 32'd0);
                end else begin
                    e = busQ.pop_front();
                    check({e.name, "_data"}, peripheralBus_dataRead, e.data);
                    check({e.name, "_req"}, 32'(requestOutput), 32'(e.req));
                    check({e.name, "_busy"}, 32'(peripheralBus_busy), 32'd0);
                end
            end
            if (gotMisoQ.size() != 0) begin
                g = gotMisoQ.pop_front();
                if (expMisoQ.size() == 0) begin
                    check("unexpected_miso", 32'(g), 32'hFFFF_FFFF);
                end else begin
                    x = expMisoQ.pop_front();
                    check("miso_byte", 32'(g), 32'(x));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic busWrite(input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] bs);
        @(posedge clk);
        #1;
        peripheralEnable         = 1'b1;
        peripheralBus_we         = 1'b1;
        peripheralBus_address    = a;
        peripheralBus_dataWrite  = d;
        peripheralBus_byteSelect = bs;
        @(posedge clk);
        #1;
        peripheralEnable         = 1'b0;
        peripheralBus_we         = 1'b0;
        peripheralBus_byteSelect = 4'h0;
    endtask

    task automatic busRead(input logic [15:0] a, input logic [31:0] e,
                           input logic req, input string n);
        @(posedge clk);
        #1;
        busQ.push_back('{name: n, data: e, req: req});
        peripheralEnable      = 1'b1;
        peripheralBus_oe      = 1'b1;
        peripheralBus_address = a;
        @(posedge clk);
        #1;
        peripheralEnable = 1'b0;
        peripheralBus_oe = 1'b0;
    endtask

    task automatic csOn();
        @(posedge clk);
        #2;
        spi_cs = 1'b0;
        #HALF;
    endtask

    task automatic csOff();
        #HALF;
        spi_cs = 1'b1;
        #HALF;
    endtask

    task automatic spiXfer(input logic cpol, input logic cpha, input logic msb,
                           input logic [7:0] tx, input int nbits);
        logic [7:0] got;
        int idx;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = msb ? 7 - i : i;
            if (!cpha) begin
                spi_mosi = tx[idx];
                #HALF;
                spi_sclk = ~cpol;
                got[idx] = spi_miso;
                #HALF;
                spi_sclk = cpol;
            end else begin
                spi_sclk = ~cpol;
                spi_mosi = tx[idx];
                #HALF;
                spi_sclk = cpol;
                got[idx] = spi_miso;
                #HALF;
            end
        end
        if (nbits == 8) gotMisoQ.push_back(got);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_miso_en", 32'(spi_miso_en), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_req", 32'(requestOutput), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        busRead(A_CFG, 32'h04, 1'b1, "rst_cfg");
        busRead(A_STAT, 32'h02, 1'b1, "rst_stat");
        busRead(A_DATA, 32'h00, 1'b1, "rst_data");
        busRead(16'h000C, 32'hFFFF_FFFF, 1'b0, "unmapped");
        busRead(16'h1004, 32'hFFFF_FFFF, 1'b0, "other_id");

        // Config masking and byte lane
        busWrite(A_CFG, 32'h10, 4'h2);
        busRead(A_CFG, 32'h04, 1'b1, "cfg_lane_ignored");
        busWrite(A_CFG, 32'hE8, 4'h1);
`ifdef SPI_TARGET_IRQ_EN
        busRead(A_CFG, 32'hE8, 1'b1, "cfg_upper");
`else
        busRead(A_CFG, 32'h08, 1'b1, "cfg_upper");
`endif

        // Mode 0, MSB first
        busWrite(A_CFG, 32'h14, 4'h1);
        busWrite(A_DATA, 32'hA5, 4'h1);
        busRead(A_STAT, 32'h00, 1'b1, "m0_stat_pre");
        csOn();
        check("m0_miso_en", 32'(spi_miso_en), 32'd1);
        expMisoQ.push_back(8'hA5);
        spiXfer(1'b0, 1'b0, 1'b1, 8'h3C, 8);
        busRead(A_STAT, 32'h0B, 1'b1, "m0_stat_done");
        busRead(A_DATA, 32'h3C, 1'b1, "m0_data");
        busRead(A_STAT, 32'h0A, 1'b1, "m0_stat_read");
        csOff();
        busRead(A_STAT, 32'h02, 1'b1, "m0_stat_idle");

        // Mode 3, LSB first
        spi_sclk = 1'b1;
        busWrite(A_CFG, 32'h13, 4'h1);
        busWrite(A_DATA, 32'h81, 4'h1);
        csOn();
        expMisoQ.push_back(8'h81);
        spiXfer(1'b1, 1'b1, 1'b0, 8'h0F, 8);
        csOff();
        busRead(A_DATA, 32'h0F, 1'b1, "m3_data");
        busRead(A_STAT, 32'h02, 1'b1, "m3_stat");

        // Overrun, empty TX and mid-byte write
        spi_sclk = 1'b0;
        busWrite(A_CFG, 32'h14, 4'h1);
        csOn();
        expMisoQ.push_back(8'hFF);
        expMisoQ.push_back(8'h55);
        fork
            spiXfer(1'b0, 1'b0, 1'b1, 8'h11, 8);
            begin
                repeat (40) @(posedge clk);
                busWrite(A_DATA, 32'h55, 4'h1);
            end
        join
        spiXfer(1'b0, 1'b0, 1'b1, 8'h22, 8);
        csOff();
        busRead(A_STAT, 32'h07, 1'b1, "ovr_stat");
        busRead(A_DATA, 32'h11, 1'b1, "ovr_data");
        busWrite(A_STAT, 32'h4, 4'h1);
        busRead(A_STAT, 32'h02, 1'b1, "ovr_clear");

        // Partial byte abort
        csOn();
        spiXfer(1'b0, 1'b0, 1'b1, 8'hF0, 4);
        busRead(A_STAT, 32'h1A, 1'b1, "part_busy");
        csOff();
        busRead(A_STAT, 32'h02, 1'b1, "part_idle");
        check("part_miso_en", 32'(spi_miso_en), 32'd0);
        csOn();
        expMisoQ.push_back(8'hFF);
        spiXfer(1'b0, 1'b0, 1'b1, 8'hC3, 8);
        csOff();
        busRead(A_DATA, 32'hC3, 1'b1, "part_next");

        // Asynchronous reset mid-byte
        busWrite(A_DATA, 32'h99, 4'h1);
        csOn();
        spiXfer(1'b0, 1'b0, 1'b1, 8'h12, 3);
        check("rstmid_miso_en_pre", 32'(spi_miso_en), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("rstmid_miso_en", 32'(spi_miso_en), 32'd0);
        check("rstmid_miso", 32'(spi_miso), 32'd0);
        busRead(A_CFG, 32'h04, 1'b1, "rstmid_cfg");
        busRead(A_STAT, 32'h02, 1'b1, "rstmid_stat");
        busRead(A_DATA, 32'h00, 1'b1, "rstmid_data");
        rst = 1'b1;
        spi_cs = 1'b1;
        busRead(A_STAT, 32'h02, 1'b1, "rstmid_after");

        repeat (5) @(posedge clk);
        check("queues_drained",
              32'(busQ.size() + expMisoQ.size() + gotMisoQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
